// File: rtl/dec_pkg.sv
// Shared decode constants: opcode map and immediate-extension modes for the
// pipelined decode stage.
package dec_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_B     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;

    typedef enum logic [1:0] {
        IMM_SEXT = 2'd0,
        IMM_ZEXT = 2'd1,
        IMM_HI   = 2'd2,
        IMM_BR   = 2'd3
    } imm_mode_e;

    function automatic imm_mode_e imm_mode_of(input logic [5:0] opcode);
        imm_mode_e mode;
        case (opcode)
            OP_LUI:               mode = IMM_HI;
            OP_ANDI, OP_ORI:      mode = IMM_ZEXT;
            OP_BEQ, OP_BNE, OP_B: mode = IMM_BR;
            default:              mode = IMM_SEXT;
        endcase
        return mode;
    endfunction

endpackage

// File: rtl/regfile_bypass.sv
// Two-read, one-write register file with x0 hardwired to zero and
// same-cycle write-through to both read ports.
module regfile_bypass #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [REG_ADDR_W-1:0] raddr_a,
    input  logic [REG_ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0]     rdata_a,
    output logic [DATA_W-1:0]     rdata_b
);

    localparam int ENTRIES = 1 << REG_ADDR_W;

    logic [DATA_W-1:0] regs [ENTRIES];
    logic              wr_live;

    assign wr_live = we && (waddr != '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[waddr] <= wdata;
        end
    end

    // The write in flight this cycle wins over stored contents.
    always_comb begin
        rdata_a = '0;
        rdata_b = '0;
        if (wr_live && (raddr_a == waddr)) begin
            rdata_a = wdata;
        end else if (raddr_a != '0) begin
            rdata_a = regs[raddr_a];
        end
        if (wr_live && (raddr_b == waddr)) begin
            rdata_b = wdata;
        end else if (raddr_b != '0) begin
            rdata_b = regs[raddr_b];
        end
    end

endmodule

// File: rtl/dec_stage_pipe.sv
// Pipelined decode stage: register read with write-back bypass, immediate
// generation, load-use stall and a valid/ready ID/EX output register.
module dec_stage_pipe
    import dec_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  Clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           Instr,
    input  logic                  wb_we,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]     wb_alu,
    input  logic [DATA_W-1:0]     wb_mem,
    input  logic                  wb_sel,
    input  logic                  ex_valid,
    input  logic                  ex_is_load,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_Immed,
    output logic [DATA_W-1:0]     out_RF_A,
    output logic [DATA_W-1:0]     out_RF_B,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [5:0]            out_opcode
);

    function automatic logic [DATA_W-1:0] ext_imm(input imm_mode_e mode,
                                                  input logic [15:0] imm);
        logic [DATA_W-1:0] v;
        case (mode)
            IMM_HI:   v = DATA_W'({imm, 16'h0000});
            IMM_ZEXT: v = {{(DATA_W-16){1'b0}}, imm};
            IMM_BR:   v = {{(DATA_W-18){imm[15]}}, imm, 2'b00};
            default:  v = {{(DATA_W-16){imm[15]}}, imm};
        endcase
        return v;
    endfunction

    // ---- p0: decode and register read ----
    logic [5:0]            opcode_p0;
    logic [REG_ADDR_W-1:0] rs_p0, rt_p0, rdf_p0, rb_addr_p0, dst_p0;
    logic [15:0]           imm_p0;
    logic                  is_rtype_p0;
    logic [DATA_W-1:0]     wb_data_p0, rf_a_p0, rf_b_p0, immed_p0;
    logic                  stall_p0, advance_p0, accept_p0;

    assign opcode_p0   = Instr[31:26];
    assign rs_p0       = Instr[21 +: REG_ADDR_W];
    assign rt_p0       = Instr[16 +: REG_ADDR_W];
    assign rdf_p0      = Instr[11 +: REG_ADDR_W];
    assign imm_p0      = Instr[15:0];
    assign is_rtype_p0 = (opcode_p0 == OP_RTYPE);
    assign rb_addr_p0  = is_rtype_p0 ? rt_p0 : rdf_p0;
    assign dst_p0      = is_rtype_p0 ? rdf_p0 : rt_p0;
    assign immed_p0    = ext_imm(imm_mode_of(opcode_p0), imm_p0);
    assign wb_data_p0  = wb_sel ? wb_mem : wb_alu;

    regfile_bypass #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_rf (
        .clk     (Clk),
        .reset   (reset),
        .we      (wb_we),
        .waddr   (wb_addr),
        .wdata   (wb_data_p0),
        .raddr_a (rs_p0),
        .raddr_b (rb_addr_p0),
        .rdata_a (rf_a_p0),
        .rdata_b (rf_b_p0)
    );

    // The hazard check ignores in_valid so in_ready depends only on Instr and EX.
    assign stall_p0   = ex_valid && ex_is_load && (ex_rd != '0) &&
                        ((ex_rd == rs_p0) || (ex_rd == rb_addr_p0));
    assign advance_p0 = !out_valid || out_ready;
    assign in_ready   = advance_p0 && !stall_p0;
    assign accept_p0  = in_valid && in_ready;

    // ---- p1: ID/EX register ----
    logic                  vld_p1;
    logic [DATA_W-1:0]     immed_p1, rf_a_p1, rf_b_p1;
    logic [REG_ADDR_W-1:0] rd_p1;
    logic [5:0]            opcode_p1;

    always_ff @(posedge Clk) begin
        if (!reset) begin
            vld_p1    <= 1'b0;
            immed_p1  <= '0;
            rf_a_p1   <= '0;
            rf_b_p1   <= '0;
            rd_p1     <= '0;
            opcode_p1 <= '0;
        end else if (advance_p0) begin
            vld_p1 <= accept_p0;
            if (accept_p0) begin
                immed_p1  <= immed_p0;
                rf_a_p1   <= rf_a_p0;
                rf_b_p1   <= rf_b_p0;
                rd_p1     <= dst_p0;
                opcode_p1 <= opcode_p0;
            end
        end
    end

    assign out_valid  = vld_p1;
    assign out_Immed  = immed_p1;
    assign out_RF_A   = rf_a_p1;
    assign out_RF_B   = rf_b_p1;
    assign out_rd     = rd_p1;
    assign out_opcode = opcode_p1;

endmodule

// File: tb/tb_dec_stage_pipe.sv
// Directed bench for dec_stage_pipe: vector table plus hand-written
// reset, bypass, load-use, backpressure and mid-operation reset sequences.
module tb_dec_stage_pipe;

    logic        Clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] Instr;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_alu, wb_mem;
    logic        wb_sel;
    logic        ex_valid, ex_is_load;
    logic [4:0]  ex_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_Immed, out_RF_A, out_RF_B;
    logic [4:0]  out_rd;
    logic [5:0]  out_opcode;

    int checks = 0;
    int errors = 0;

    dec_stage_pipe #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .Clk        (Clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .Instr      (Instr),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_alu     (wb_alu),
        .wb_mem     (wb_mem),
        .wb_sel     (wb_sel),
        .ex_valid   (ex_valid),
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_Immed  (out_Immed),
        .out_RF_A   (out_RF_A),
        .out_RF_B   (out_RF_B),
        .out_rd     (out_rd),
        .out_opcode (out_opcode)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] instr;
        logic        exv;
        logic        exl;
        logic [4:0]  exrd;
        logic        rdy;
        logic [31:0] imm;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_zero_outs(input string tag);
        check({tag, "_vld"}, 32'(out_valid), 32'd0);
        check({tag, "_imm"}, out_Immed, 32'd0);
        check({tag, "_a"}, out_RF_A, 32'd0);
        check({tag, "_b"}, out_RF_B, 32'd0);
        check({tag, "_rd"}, 32'(out_rd), 32'd0);
        check({tag, "_op"}, 32'(out_opcode), 32'd0);
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; Instr = '0; wb_we = 1'b0; wb_addr = '0;
        wb_alu = '0; wb_mem = '0; wb_sel = 1'b0; ex_valid = 1'b0; ex_is_load = 1'b0;
        ex_rd = '0; out_ready = 1'b1;

        vecs[0]  = '{mk(6'h0F,5'd1,5'd2,16'h8004), 0,0,5'd0, 1, 32'h8004_0000, 32'h1001, 32'h0,    5'd2};
        vecs[1]  = '{mk(6'h0D,5'd3,5'd4,16'h8004), 0,0,5'd0, 1, 32'h0000_8004, 32'h1003, 32'h0,    5'd4};
        vecs[2]  = '{mk(6'h04,5'd5,5'd6,16'h8004), 0,0,5'd0, 1, 32'hFFFE_0010, 32'h1005, 32'h0,    5'd6};
        vecs[3]  = '{mk(6'h23,5'd7,5'd1,16'h8004), 0,0,5'd0, 1, 32'hFFFF_8004, 32'h1007, 32'h0,    5'd1};
        vecs[4]  = '{mk(6'h00,5'd1,5'd2,16'h1820), 0,0,5'd0, 1, 32'h0000_1820, 32'h1001, 32'h1002, 5'd3};
        vecs[5]  = '{mk(6'h0C,5'd2,5'd0,16'h0010), 0,0,5'd0, 1, 32'h0000_0010, 32'h1002, 32'h0,    5'd0};
        vecs[6]  = '{mk(6'h05,5'd4,5'd0,16'h2800), 0,0,5'd0, 1, 32'h0000_A000, 32'h1004, 32'h1005, 5'd0};
        vecs[7]  = '{mk(6'h00,5'd1,5'd2,16'h1800), 1,1,5'd0, 1, 32'h0000_1800, 32'h1001, 32'h1002, 5'd3};
        vecs[8]  = '{mk(6'h00,5'd1,5'd2,16'h1800), 1,1,5'd4, 1, 32'h0000_1800, 32'h1001, 32'h1002, 5'd3};
        vecs[9]  = '{mk(6'h0D,5'd3,5'd4,16'h0001), 1,1,5'd3, 0, 32'h0,         32'h0,    32'h0,    5'd0};
        vecs[10] = '{mk(6'h05,5'd1,5'd0,16'h2800), 1,1,5'd5, 0, 32'h0,         32'h0,    32'h0,    5'd0};
        vecs[11] = '{mk(6'h00,5'd1,5'd2,16'h1800), 1,0,5'd1, 1, 32'h0000_1800, 32'h1001, 32'h1002, 5'd3};
        vecs[12] = '{mk(6'h00,5'd1,5'd2,16'h1800), 1,1,5'd2, 0, 32'h0,         32'h0,    32'h0,    5'd0};
        vecs[13] = '{mk(6'h0D,5'd1,5'd2,16'h0000), 1,1,5'd2, 1, 32'h0000_0000, 32'h1001, 32'h0,    5'd2};

        // Reset held for two edges, outputs checked while still in reset.
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check_zero_outs("rst");
        tick();
        reset = 1'b1;

        // Write all-ones to x0 while reading x0 on both ports, then read again.
        wb_we = 1'b1; wb_addr = 5'd0; wb_alu = 32'hFFFF_FFFF; wb_sel = 1'b0;
        in_valid = 1'b1; Instr = mk(6'h00, 5'd0, 5'd0, 16'h0000);
        tick();
        check("x0_wr_vld", 32'(out_valid), 32'd1);
        check("x0_wr_a", out_RF_A, 32'd0);
        check("x0_wr_b", out_RF_B, 32'd0);
        wb_we = 1'b0;
        tick();
        check("x0_rd_a", out_RF_A, 32'd0);
        check("x0_rd_b", out_RF_B, 32'd0);

        // Preload x1..x7 = 0x1000+k, alternating write-back source.
        in_valid = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            wb_we = 1'b1; wb_addr = 5'(k); wb_sel = k[0];
            if (k[0]) begin
                wb_mem = 32'h1000 + 32'(k); wb_alu = 32'hBAD0_0000 + 32'(k);
            end else begin
                wb_alu = 32'h1000 + 32'(k); wb_mem = 32'hBAD0_0000 + 32'(k);
            end
            tick();
        end
        wb_we = 1'b0;
        tick();

        // Vector table.
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            Instr = vecs[i].instr; ex_valid = vecs[i].exv;
            ex_is_load = vecs[i].exl; ex_rd = vecs[i].exrd;
            @(negedge Clk);
            check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
            tick();
            check($sformatf("v%0d_vld", i), 32'(out_valid), 32'(vecs[i].rdy));
            if (vecs[i].rdy) begin
                check($sformatf("v%0d_imm", i), out_Immed, vecs[i].imm);
                check($sformatf("v%0d_a", i), out_RF_A, vecs[i].a);
                check($sformatf("v%0d_b", i), out_RF_B, vecs[i].b);
                check($sformatf("v%0d_rd", i), 32'(out_rd), 32'(vecs[i].rd));
                check($sformatf("v%0d_op", i), 32'(out_opcode), 32'(vecs[i].instr[31:26]));
            end
        end
        ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd = '0;

        // Bypass of the same-cycle write to both read ports.
        wb_we = 1'b1; wb_addr = 5'd5; wb_sel = 1'b1;
        wb_mem = 32'hDEAD_BEEF; wb_alu = 32'h1234_5678;
        Instr = mk(6'h00, 5'd5, 5'd5, 16'h3000);
        tick();
        check("byp_a", out_RF_A, 32'hDEAD_BEEF);
        check("byp_b", out_RF_B, 32'hDEAD_BEEF);
        wb_we = 1'b0;

        // Load-use stall for one cycle, then release.
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd3;
        Instr = mk(6'h00, 5'd3, 5'd1, 16'h1000);
        @(negedge Clk);
        check("lu_in_ready", 32'(in_ready), 32'd0);
        tick();
        check("lu_bubble", 32'(out_valid), 32'd0);
        ex_valid = 1'b0;
        @(negedge Clk);
        check("lu_rel_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("lu_rel_vld", 32'(out_valid), 32'd1);
        check("lu_rel_a", out_RF_A, 32'h1003);
        check("lu_rel_b", out_RF_B, 32'h1001);
        check("lu_rel_rd", 32'(out_rd), 32'd2);

        // Backpressure: 3 stalled cycles, then a 10-instruction stream.
        ex_is_load = 1'b0; ex_rd = '0;
        Instr = mk(6'h23, 5'd0, 5'd0, 16'h0040);
        tick();
        out_ready = 1'b0;
        Instr = mk(6'h08, 5'd0, 5'd0, 16'h0100);
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk);
            check($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'd0);
            check($sformatf("bp%0d_vld", c), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d_imm", c), out_Immed, 32'h40);
            check($sformatf("bp%0d_op", c), 32'(out_opcode), 32'h23);
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            Instr = mk(6'h08, 5'd0, 5'd0, 16'h0100 + 16'(i));
            @(negedge Clk);
            check($sformatf("st%0d_in_ready", i), 32'(in_ready), 32'd1);
            check($sformatf("st%0d_vld", i), 32'(out_valid), 32'd1);
            check($sformatf("st%0d_imm", i), out_Immed, (i == 0) ? 32'h40 : 32'h100 + 32'(i - 1));
            tick();
        end
        check("st_last_vld", 32'(out_valid), 32'd1);
        check("st_last_imm", out_Immed, 32'h109);
        in_valid = 1'b0;
        tick();
        check("st_drain_vld", 32'(out_valid), 32'd0);

        // Reset arriving while the output is valid and a stall is active.
        in_valid = 1'b1; Instr = mk(6'h00, 5'd1, 5'd2, 16'h1800);
        tick();
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd1;
        reset = 1'b0;
        @(negedge Clk);
        check("mr_pre_vld", 32'(out_valid), 32'd1);
        check("mr_pre_in_ready", 32'(in_ready), 32'd0);
        tick();
        check_zero_outs("mr");
        reset = 1'b1; ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd = '0;
        tick();
        check("mr_post_vld", 32'(out_valid), 32'd1);
        check("mr_post_a", out_RF_A, 32'd0);
        check("mr_post_b", out_RF_B, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dec_stage_pipe.md
# dec_stage_pipe

Parametrised, pipelined successor of the single-cycle decode stage. Decodes one instruction per cycle, reads a `2**REG_ADDR_W`-entry register file with write-back bypass, generates the extended immediate, and registers results into an ID/EX output register behind a valid/ready handshake. Detects load-use hazards against the instruction in EX and stalls the fetch side while inserting a bubble. Sits between the fetch stage and the execute stage.

## Interface
- `DATA_W`, default 32: register and immediate width; must be at least 32.
- `REG_ADDR_W`, default 5: register address width; the file holds `2**REG_ADDR_W` entries.
- `Clk  in  1`: single clock; all state changes on its rising edge.
- `reset  in  1`: synchronous, active-low reset.
- `in_valid  in  1`: fetch presents `Instr`.
- `in_ready  out  1`: the stage accepts `Instr` this cycle.
- `Instr  in  32`: instruction. Fields: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], imm [15:0]. Only the low `REG_ADDR_W` bits of each address field are used.
- `wb_we  in  1`: register-file write enable.
- `wb_addr  in  REG_ADDR_W`: write address.
- `wb_alu`, `wb_mem  in  DATA_W`: write-back candidates.
- `wb_sel  in  1`: 0 selects `wb_alu`, 1 selects `wb_mem`.
- `ex_valid`, `ex_is_load  in  1`: EX holds a valid load.
- `ex_rd  in  REG_ADDR_W`: destination of the EX instruction.
- `out_valid  out  1`: the ID/EX register holds a valid instruction.
- `out_ready  in  1`: EX accepts it.
- `out_Immed`, `out_RF_A`, `out_RF_B  out  DATA_W`: registered operands.
- `out_rd  out  REG_ADDR_W`: destination; rt for I-type, rd for R-type.
- `out_opcode  out  6`: registered opcode.

## Operation
- **Reset** (`reset`=0 at an edge):
  - All registers are cleared to 0.
  - `out_valid`=0, and all `out_*` data are 0.
  - `reset` overrides any in-flight transfer or write in that cycle.
- **Register file:**
  - Register 0 reads as 0; writes to it are ignored.
  - A write occurs at the edge when `wb_we`=1.
  - Write data = `wb_sel ? wb_mem : wb_alu`.
- **Bypass:** if a read address equals `wb_addr` (nonzero) while `wb_we`=1, the read returns the write data of that same cycle.
- **Port B address:**
  - R-type (opcode `OP_RTYPE`): rt.
  - All other opcodes: rd (store/branch convention).
- **Immediate:**
  - `OP_LUI`: imm << 16.
  - `OP_ANDI`, `OP_ORI`: imm zero-extended.
  - `OP_BEQ`, `OP_BNE`, `OP_B`: imm sign-extended, then << 2.
  - All others: imm sign-extended.
  - Extension always fills to `DATA_W`.
- **Hazard:** `stall` = `ex_valid & ex_is_load & ex_rd`≠0 & (`ex_rd`==rs | `ex_rd`==port-B address).
- **Handshake:**
  - `advance` = !`out_valid` | `out_ready`.
  - `in_ready` = `advance` & !`stall`.
  - A transfer is accepted when `in_valid` & `in_ready`.
- **On an edge with `advance`=1:**
  - Accepted: load the ID/EX register, and set `out_valid`=1.
  - Not accepted (stall or no input): `out_valid`=0 (bubble); data outputs hold their previous values.
- **On an edge with `advance`=0:** the ID/EX register holds all values.

## Timing
- Latency is 1 cycle from the accepting edge to `out_valid`; throughput is 1 instruction/cycle with no stall.
- A load-use stall lasts exactly as long as the condition holds. Usually 1 cycle, since EX advances and `ex_valid` then drops or changes.
- `in_ready` is combinational from `ex_*`, `out_valid`, `out_ready` and `Instr`. Fetch must hold `Instr` stable while `in_valid`=1 and `in_ready`=0.
- A register-file write and an ID/EX capture in the same cycle are coherent through the bypass.
- When both read ports hit the same written register, both are bypassed.

## Structure
- Package `dec_pkg`: opcode constants `OP_RTYPE`, `OP_LUI`, `OP_ANDI`, `OP_ORI`, `OP_BEQ`, `OP_BNE`, `OP_B`, `OP_LW`; immediate-mode encoding (`IMM_SEXT`, `IMM_ZEXT`, `IMM_HI`, `IMM_BR`).
- One sub-module, `regfile_bypass`: parametrised in `DATA_W` and `REG_ADDR_W`, with 2 read ports, 1 write port and write-through. The hazard logic, immediate unit and ID/EX register live in the top module.

## Test plan
- **Reset and x0:** hold `reset`=0 for 2 cycles, then write 0xFFFF_FFFF to x0. Required: `out_valid`=0 during reset, and a read of x0 returns 0.
- **Bypass:** `wb_we`=1, `wb_addr`=5, `wb_sel`=1, `wb_mem`=0xDEAD_BEEF, with an R-type instruction reading rs=5 and rt=5 in the same cycle. Required: next cycle `out_RF_A` = `out_RF_B` = 0xDEAD_BEEF.
- **Immediates** (imm=0x8004):
  - `OP_LUI` → 0x8004_0000.
  - `OP_ORI` → 0x0000_8004.
  - `OP_BEQ` → 0xFFFE_0010.
  - `OP_LW` → 0xFFFF_8004.
- **Load-use:** `ex_valid`=1, `ex_is_load`=1, `ex_rd`=3, instruction with rs=3. Required: `in_ready`=0, and the next cycle has `out_valid`=0. Drop `ex_valid`; required: the instruction is accepted on the following cycle. Repeat with `ex_rd`=0; required: no stall.
- **Backpressure:** hold `out_ready`=0 for 3 cycles with a valid output. Required: `in_ready`=0 and `out_*` stable; on release, one transfer per cycle with no loss or duplication over 10 instructions.
- **Mid-operation reset:** assert `reset`=0 while `out_valid`=1 and a stall is active. Required: next cycle `out_valid`=0 and all registers read 0.
